calc2_port_sched: RTL and testbench

- Per-port request scheduler in front of one calc2 request/response port (req1..req4).
- Accepts operations from a client over a valid/ready handshake and allocates one of four 2-bit tags.
- Drives the calc2 two-cycle request protocol (cycle 1: cmd, operand 1, tag; cycle 2: cmd=0, operand 2), matches out-of-order responses by tag, and returns results through a 4-entry result FIFO.
- Retires tags whose response exceeds a timeout.

---
 rtl/calc2_port_sched.sv | 214 +++++++++++++++++++++
 tb/tb_calc2_port_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_port_sched.sv
// Request scheduler for one calc2 port: allocates 2-bit tags, issues the two-cycle
// request, matches out-of-order responses by tag, retires stuck tags by timeout.

module calc2_port_sched_tag #(
  parameter int TIMEOUT = 64,
  parameter int TCW     = 7
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       send1,
  input  logic       resp_hit,
  input  logic       to_fire,
  input  logic       pop_hit,
  output logic [1:0] st,
  output logic       expired
);
  localparam logic [1:0] T_FREE = 2'd0, T_ISSUED = 2'd1, T_BUF = 2'd2, T_DEAD = 2'd3;
  localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT);

  logic [TCW-1:0] cnt;

  // The SEND1 cycle counts as the first elapsed cycle, so expiry lands TIMEOUT cycles after it.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      st  <= T_FREE;
      cnt <= '0;
    end else begin
      if (start) cnt <= '0;
      else if ((send1 || st == T_ISSUED) && cnt != TMAX) cnt <= cnt + 1'b1;
      if (send1)                       st <= T_ISSUED;
      else if (resp_hit)               st <= T_BUF;
      else if (to_fire)                st <= T_DEAD;
      else if (pop_hit && st == T_BUF) st <= T_FREE;
    end
  end

  assign expired = (st == T_ISSUED) && (cnt == TMAX);
endmodule

module calc2_port_sched #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int TCW     = 7
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_cmd,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [1:0]    op_tag,
  output logic [3:0]    req_cmd_out,
  output logic [DW-1:0] req_data_out,
  output logic [1:0]    req_tag_out,
  input  logic [1:0]    out_resp,
  input  logic [DW-1:0] out_data,
  input  logic [1:0]    out_tag,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [1:0]    res_resp,
  output logic [DW-1:0] res_data,
  output logic [1:0]    res_tag,
  output logic          busy,
  output logic [3:0]    dead_tags,
  output logic          proto_err
);
  localparam int NUM_TAGS = 4;
  localparam logic [1:0] T_FREE = 2'd0, T_ISSUED = 2'd1, T_BUF = 2'd2, T_DEAD = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND1, SEND2} fsm_t;
  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [1:0]    tag;
  } res_t;

  fsm_t                          state, state_nxt;
  logic [3:0]                    cmd_l;
  logic [DW-1:0]                 a_l, b_l;
  logic [1:0]                    tag_l;
  logic [NUM_TAGS-1:0][1:0]      tag_st;
  logic [NUM_TAGS-1:0]           expired, start, send1, resp_hit, to_fire, pop_hit, live;
  logic                          any_free, any_to;
  logic [1:0]                    free_tag, to_tag;
  logic                          accept, resp_v, resp_push, to_push, push, pop;
  res_t                          fifo [NUM_TAGS];
  res_t                          head, push_ent;
  logic [1:0]                    wp, rp;
  logic [2:0]                    count;

  // Lowest-numbered FREE tag for allocation, lowest expired tag for timeout service.
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    any_to   = 1'b0;
    to_tag   = '0;
    for (int i = NUM_TAGS-1; i >= 0; i--) begin
      if (tag_st[i] == T_FREE) begin any_free = 1'b1; free_tag = 2'(i); end
      if (expired[i])          begin any_to   = 1'b1; to_tag   = 2'(i); end
    end
  end

  assign op_ready = reset && (state == IDLE || state == SEND2) && any_free;
  assign op_tag   = free_tag;
  assign accept   = op_valid && op_ready;

  always_comb begin
    state_nxt    = state;
    req_cmd_out  = '0;
    req_data_out = '0;
    req_tag_out  = '0;
    case (state)
      IDLE:  if (accept) state_nxt = SEND1;
      SEND1: begin
        state_nxt    = SEND2;
        req_cmd_out  = cmd_l;
        req_data_out = a_l;
        req_tag_out  = tag_l;
      end
      SEND2: begin
        state_nxt    = accept ? SEND1 : IDLE;
        req_data_out = b_l;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cmd_l <= '0;
      a_l   <= '0;
      b_l   <= '0;
      tag_l <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_l <= op_cmd;
        a_l   <= op_a;
        b_l   <= op_b;
        tag_l <= free_tag;
      end
    end
  end

  // A real response always takes the single push slot; a pending timeout waits a cycle.
  assign resp_v    = |out_resp;
  assign resp_push = resp_v && (tag_st[out_tag] == T_ISSUED);
  assign to_push   = any_to && !resp_push;
  assign push      = resp_push || to_push;
  assign pop       = res_valid && res_ready;

  always_comb begin
    push_ent = '0;
    if (resp_push) begin
      push_ent.resp = out_resp;
      push_ent.data = out_data;
      push_ent.tag  = out_tag;
    end else begin
      push_ent.resp = 2'd3;
      push_ent.tag  = to_tag;
    end
  end

  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    assign start[g]     = accept && (free_tag == 2'(g));
    assign send1[g]     = (state == SEND1) && (tag_l == 2'(g));
    assign resp_hit[g]  = resp_push && (out_tag == 2'(g));
    assign to_fire[g]   = to_push && (to_tag == 2'(g));
    assign pop_hit[g]   = pop && (head.tag == 2'(g));
    assign live[g]      = (tag_st[g] == T_ISSUED) || (tag_st[g] == T_BUF);
    assign dead_tags[g] = (tag_st[g] == T_DEAD);

    calc2_port_sched_tag #(.TIMEOUT(TIMEOUT), .TCW(TCW)) u_tag (
      .c_clk    (c_clk),
      .reset    (reset),
      .start    (start[g]),
      .send1    (send1[g]),
      .resp_hit (resp_hit[g]),
      .to_fire  (to_fire[g]),
      .pop_hit  (pop_hit[g]),
      .st       (tag_st[g]),
      .expired  (expired[g])
    );
  end

  // Occupancy is bounded by live tags, so the FIFO needs no full check.
  always_ff @(posedge c_clk) begin
    if (push) fifo[wp] <= push_ent;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + 3'(push) - 3'(pop);
      if (resp_v && tag_st[out_tag] != T_ISSUED && tag_st[out_tag] != T_DEAD) proto_err <= 1'b1;
    end
  end

  assign head      = fifo[rp];
  assign res_valid = (count != 3'd0);
  assign res_resp  = res_valid ? head.resp : '0;
  assign res_data  = res_valid ? head.data : '0;
  assign res_tag   = res_valid ? head.tag  : '0;
  assign busy      = (state != IDLE) || (|live);
endmodule

// File: tb/tb_calc2_port_sched.sv
// Bench for calc2_port_sched: timestamp/queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_calc2_port_sched;
  localparam int DW = 32, T = 16, TCW = 5;
  localparam int FREE = 0, ISSUED = 1, BUF = 2, DEAD = 3;

  logic          c_clk = 1'b0, reset = 1'b0;
  logic          op_valid = 1'b0, op_ready;
  logic [3:0]    op_cmd = '0;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic [1:0]    op_tag;
  logic [3:0]    req_cmd_out;
  logic [DW-1:0] req_data_out;
  logic [1:0]    req_tag_out;
  logic [1:0]    out_resp = '0;
  logic [DW-1:0] out_data = '0;
  logic [1:0]    out_tag = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [1:0]    res_resp;
  logic [DW-1:0] res_data;
  logic [1:0]    res_tag;
  logic          busy, proto_err;
  logic [3:0]    dead_tags;

  always #5 c_clk = ~c_clk;

  calc2_port_sched #(.DW(DW), .TIMEOUT(T), .TCW(TCW)) dut (
    .c_clk(c_clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_resp(res_resp),
    .res_data(res_data), .res_tag(res_tag), .busy(busy), .dead_tags(dead_tags),
    .proto_err(proto_err)
  );

  int passed = 0, total = 0;
  int tb_cyc = 0;
  always @(posedge c_clk) tb_cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tag states, SEND1 timestamps, result queue.
  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [1:0]    tag;
  } ent_t;
  ent_t          mq[$];
  int            m_st[4];
  int            iss_cyc[4];
  int            cyc = 0, acc_cyc = -10, acc_tag = 0;
  logic [3:0]    acc_cmd = '0;
  logic [DW-1:0] acc_a = '0, acc_b = '0;
  bit            m_proto = 0, chk_en = 0;
  logic [3:0]    cmds[4] = '{4'd1, 4'd2, 4'd5, 4'd6};

  task automatic m_clear();
    for (int t = 0; t < 4; t++) begin m_st[t] = FREE; iss_cyc[t] = 0; end
    mq.delete();
    cyc = 0; acc_cyc = -10; acc_tag = 0; m_proto = 0;
  endtask

  always @(negedge c_clk) begin : cmp
    int lf, to_t;
    bit s1, s2, e_rdy, busy_e, rpush;
    logic [3:0] dead_e;
    logic [37:0] e_req;
    logic [36:0] e_res;
    ent_t ent;
    if (chk_en) begin
      if (!reset) m_clear();
      s1 = (cyc == acc_cyc + 1);
      s2 = (cyc == acc_cyc + 2);
      lf = -1;
      for (int t = 3; t >= 0; t--) if (m_st[t] == FREE) lf = t;
      e_rdy = reset && !s1 && (lf >= 0);
      chk("op_ready", op_ready, e_rdy);
      if (op_valid && e_rdy) chk("op_tag", op_tag, lf);
      e_req = s1 ? {acc_cmd, acc_a, 2'(acc_tag)} : (s2 ? {4'd0, acc_b, 2'd0} : '0);
      chk("req", {req_cmd_out, req_data_out, req_tag_out}, e_req);
      e_res = (mq.size() > 0) ? {1'b1, mq[0].resp, mq[0].data, mq[0].tag} : '0;
      chk("res", {res_valid, res_resp, res_data, res_tag}, e_res);
      busy_e = s1 || s2;
      for (int t = 0; t < 4; t++) begin
        if (m_st[t] == ISSUED || m_st[t] == BUF) busy_e = 1;
        dead_e[t] = (m_st[t] == DEAD);
      end
      chk("status", {busy, dead_tags, proto_err}, {busy_e, dead_e, m_proto});

      if (reset) begin
        rpush = (out_resp != 0) && (m_st[out_tag] == ISSUED);
        if (out_resp != 0 && m_st[out_tag] != ISSUED && m_st[out_tag] != DEAD) m_proto = 1;
        to_t = -1;
        for (int t = 3; t >= 0; t--)
          if (m_st[t] == ISSUED && cyc - iss_cyc[t] >= T) to_t = t;
        if (mq.size() > 0 && res_ready) begin
          ent = mq.pop_front();
          if (m_st[ent.tag] != DEAD) m_st[ent.tag] = FREE;
        end
        if (rpush) begin
          ent.resp = out_resp; ent.data = out_data; ent.tag = out_tag;
          mq.push_back(ent);
          m_st[out_tag] = BUF;
        end else if (to_t >= 0) begin
          ent.resp = 2'd3; ent.data = '0; ent.tag = 2'(to_t);
          mq.push_back(ent);
          m_st[to_t] = DEAD;
        end
        if (s1) begin m_st[acc_tag] = ISSUED; iss_cyc[acc_tag] = cyc; end
        if (op_valid && e_rdy) begin
          acc_cyc = cyc; acc_cmd = op_cmd; acc_a = op_a; acc_b = op_b; acc_tag = lf;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; op_valid = 1'b0; out_resp = '0; res_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Returns in the SEND1 cycle of the accepted op.
  task automatic issue(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [1:0] t);
    bit ok;
    ok = 0; t = '0;
    op_valid = 1'b1; op_cmd = c; op_a = a; op_b = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge c_clk);
      if (op_ready) begin ok = 1; t = op_tag; end
      tick();
    end
    op_valid = 1'b0;
    if (!ok) chk("issue_wait", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] t;
    int s, rt;
    chk_en = 1;
    tick(); tick();
    chk("rst_outputs", {op_ready, req_cmd_out, req_data_out, req_tag_out}, 0);
    chk("rst_status", {res_valid, res_resp, res_data, res_tag, busy, dead_tags, proto_err}, 0);
    reset = 1'b1;

    // single subtract
    issue(4'd2, 32'h22, 32'h3, t);
    chk("t1_tag", t, 0);
    chk("t1_send1", {req_cmd_out, req_data_out, req_tag_out}, {4'd2, 32'h22, 2'd0});
    tick();
    chk("t1_send2", {req_cmd_out, req_data_out, req_tag_out}, {4'd0, 32'h3, 2'd0});
    out_resp = 2'd1; out_data = 32'h1F; out_tag = 2'd0;
    tick(); out_resp = '0;
    chk("t1_res", {res_valid, res_resp, res_data, res_tag}, {1'b1, 2'd1, 32'h1F, 2'd0});
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("t1_idle", {res_valid, busy}, 0);

    // fill and stall
    op_valid = 1'b1; op_cmd = 4'd1; op_a = 32'h10; op_b = 32'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge c_clk);
      chk("t2_rdy", op_ready, 1);
      chk("t2_tag", op_tag, i);
      tick();
      chk("t2_send1", {req_cmd_out, req_tag_out}, {4'd1, 2'(i)});
      tick();
    end
    chk("t2_full", op_ready, 0);
    out_resp = 2'd1; out_tag = 2'd2; out_data = 32'h55;
    tick(); out_resp = '0; res_ready = 1'b1;
    chk("t2_head", {res_valid, res_tag, op_ready}, {1'b1, 2'd2, 1'b0});
    tick(); res_ready = 1'b0;
    chk("t2_realloc", {op_ready, op_tag}, {1'b1, 2'd2});
    tick(); op_valid = 1'b0;
    do_reset();

    // out-of-order responses
    issue(4'd1, 32'h5, 32'h6, t); chk("t3_tag0", t, 0);
    issue(4'd1, 32'h7, 32'h8, t); chk("t3_tag1", t, 1);
    tick();
    out_resp = 2'd1; out_tag = 2'd1; out_data = 32'hA; tick();
    out_tag = 2'd0; out_data = 32'hB; tick(); out_resp = '0;
    chk("t3_first", {res_valid, res_resp, res_data, res_tag}, {1'b1, 2'd1, 32'hA, 2'd1});
    res_ready = 1'b1; tick();
    chk("t3_second", {res_valid, res_resp, res_data, res_tag}, {1'b1, 2'd1, 32'hB, 2'd0});
    tick(); res_ready = 1'b0;
    chk("t3_empty", res_valid, 0);
    do_reset();

    // timeout
    issue(4'd1, 32'h1, 32'h1, t);
    repeat (T) tick();
    chk("t4_pre", res_valid, 0);
    tick();
    chk("t4_res", {res_valid, res_resp, res_data, res_tag}, {1'b1, 2'd3, 32'h0, 2'd0});
    chk("t4_dead", dead_tags, 4'b0001);
    out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h99; tick(); out_resp = '0;
    chk("t4_drop", {proto_err, res_resp, res_tag}, {1'b0, 2'd3, 2'd0});
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("t4_empty", res_valid, 0);
    issue(4'd1, 32'h2, 32'h2, t);
    chk("t4_next", t, 1);
    do_reset();

    // response collides with a timeout
    issue(4'd1, 32'h0, 32'h0, t);
    issue(4'd1, 32'h0, 32'h0, t);
    s = tb_cyc;
    tick();
    out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h1; tick(); out_resp = '0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    issue(4'd1, 32'h0, 32'h0, t);
    chk("t5_tag", t, 0);
    while (tb_cyc < s + T) tick();
    out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h77; tick(); out_resp = '0;
    chk("t5_first", {res_valid, res_resp, res_data, res_tag}, {1'b1, 2'd1, 32'h77, 2'd0});
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("t5_second", {res_valid, res_resp, res_data, res_tag}, {1'b1, 2'd3, 32'h0, 2'd1});
    chk("t5_dead", dead_tags, 4'b0010);
    do_reset();

    // spurious response, then async reset during SEND1
    out_resp = 2'd2; out_tag = 2'd3; out_data = 32'h5; tick(); out_resp = '0;
    chk("t6_proto", {proto_err, res_valid}, {1'b1, 1'b0});
    issue(4'd6, 32'h80, 32'h2, t);
    chk("t6_send1", req_cmd_out, 4'd6);
    #1 reset = 1'b0;
    #1;
    chk("t6_async", {op_ready, req_cmd_out, req_data_out, req_tag_out, busy, proto_err, res_valid}, 0);
    tick(); tick();
    reset = 1'b1; op_valid = 1'b1; op_cmd = 4'd1;
    @(negedge c_clk);
    chk("t6_after", {op_ready, op_tag}, {1'b1, 2'd0});
    tick(); op_valid = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) do_reset();
      op_valid  = ($urandom_range(0, 9) < 6);
      op_cmd    = cmds[$urandom_range(0, 3)];
      op_a      = $urandom;
      op_b      = $urandom;
      res_ready = 1'($urandom_range(0, 1));
      rt        = $urandom_range(0, 3);
      out_tag   = 2'(rt);
      out_data  = $urandom;
      out_resp  = '0;
      if (m_st[rt] == ISSUED && $urandom_range(0, 99) < 12) out_resp = 2'($urandom_range(1, 2));
      else if ($urandom_range(0, 99) < 2) out_resp = 2'd1;
      tick();
    end
    op_valid = 1'b0; out_resp = '0;
    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
